// File: rtl/er_scheduler_if.sv
// Request and Earthrise-control bundle for er_scheduler.
// master: requester plus engine side; slave: the scheduler.
interface er_scheduler_if #(
   parameter int unsigned ADDRW = 16
);
   logic             req_valid;
   logic             req_ready;
   logic [ADDRW-1:0] req_addr;
   logic             er_start;
   logic [ADDRW-1:0] er_pc;
   logic             er_busy;
   logic             er_done;

   modport master (
      output req_valid, req_addr, er_busy, er_done,
      input  req_ready, er_start, er_pc
   );

   modport slave (
      input  req_valid, req_addr, er_busy, er_done,
      output req_ready, er_start, er_pc
   );
endinterface

// File: rtl/er_scheduler.sv
// Launch sequencer for the Earthrise drawing engine: request handshake, optional
// frame alignment, watchdog on completion, and double-buffer flip on the next frame.
module er_scheduler #(
   parameter int unsigned    ADDRW      = 16,
   parameter int unsigned    TOW        = 24,
   parameter logic [TOW-1:0] TIMEOUT    = 24'd12_500_000,
   parameter bit             FRAME_SYNC = 1'b1
) (
   input  logic              clk_sys,
   input  logic              rst_sys,
   input  logic              frame,
   er_scheduler_if.slave     bus,
   output logic              buf_draw,
   output logic              buf_disp,
   output logic              done,
   output logic              timeout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SYNC,
      S_START,
      S_BUSY,
      S_FLIP
   } state_t;

   localparam logic [TOW-1:0] TO_LAST = TIMEOUT - {{(TOW-1){1'b0}}, 1'b1};

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_req_ready;
   logic             w_req_ready_nxt;
   logic             r_er_start;
   logic             w_er_start_nxt;
   logic [ADDRW-1:0] r_er_pc;
   logic [ADDRW-1:0] w_er_pc_nxt;
   logic             r_buf_draw;
   logic             w_buf_draw_nxt;
   logic             r_buf_disp;
   logic             w_buf_disp_nxt;
   logic             r_done;
   logic             w_done_nxt;
   logic             r_timeout;
   logic             w_timeout_nxt;
   logic [TOW-1:0]   r_cnt;
   logic [TOW-1:0]   w_cnt_nxt;
   logic [TOW-1:0]   w_cnt_inc;
   logic             w_launch;

   assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

   always_comb begin
      w_state_nxt    = r_state;
      w_er_start_nxt = 1'b0;
      w_er_pc_nxt    = r_er_pc;
      w_buf_draw_nxt = r_buf_draw;
      w_buf_disp_nxt = r_buf_disp;
      w_done_nxt     = 1'b0;
      w_timeout_nxt  = r_timeout;
      w_cnt_nxt      = r_cnt;
      w_launch       = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (bus.req_valid && r_req_ready) begin
               w_er_pc_nxt   = bus.req_addr;
               w_timeout_nxt = 1'b0;
               if (FRAME_SYNC) w_state_nxt = S_SYNC;
               else            w_launch    = 1'b1;
            end
         end
         S_SYNC: begin
            if (frame) w_launch = 1'b1;
         end
         S_START: begin
            w_launch = 1'b1;
         end
         S_BUSY: begin
            w_cnt_nxt = w_cnt_inc;
            if (bus.er_done) begin
               w_state_nxt = S_FLIP;
            end else if ((TIMEOUT != '0) && (r_cnt == TO_LAST)) begin
               w_timeout_nxt = 1'b1;
               w_state_nxt   = S_IDLE;
            end
         end
         S_FLIP: begin
            if (frame) begin
               w_buf_disp_nxt = r_buf_draw;
               w_buf_draw_nxt = ~r_buf_draw;
               w_done_nxt     = 1'b1;
               w_state_nxt    = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      // The launch decision is made in the cycle that would enter START, so an
      // idle engine sees er_start one cycle after the handshake or frame.
      if (w_launch) begin
         if (!bus.er_busy) begin
            w_er_start_nxt = 1'b1;
            w_cnt_nxt      = '0;
            w_state_nxt    = S_BUSY;
         end else begin
            w_state_nxt    = S_START;
         end
      end

      w_req_ready_nxt = (w_state_nxt == S_IDLE);
   end

   always_ff @(posedge clk_sys or posedge rst_sys) begin
      if (rst_sys) begin
         r_state     <= S_IDLE;
         r_req_ready <= 1'b0;
         r_er_start  <= 1'b0;
         r_er_pc     <= '0;
         r_buf_draw  <= 1'b1;
         r_buf_disp  <= 1'b0;
         r_done      <= 1'b0;
         r_timeout   <= 1'b0;
         r_cnt       <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_req_ready <= w_req_ready_nxt;
         r_er_start  <= w_er_start_nxt;
         r_er_pc     <= w_er_pc_nxt;
         r_buf_draw  <= w_buf_draw_nxt;
         r_buf_disp  <= w_buf_disp_nxt;
         r_done      <= w_done_nxt;
         r_timeout   <= w_timeout_nxt;
         r_cnt       <= w_cnt_nxt;
      end
   end

   assign bus.req_ready = r_req_ready;
   assign bus.er_start  = r_er_start;
   assign bus.er_pc     = r_er_pc;
   assign buf_draw      = r_buf_draw;
   assign buf_disp      = r_buf_disp;
   assign done          = r_done;
   assign timeout       = r_timeout;

endmodule

// File: tb/tb_er_scheduler.sv
// Bench for er_scheduler: one immediate-launch instance and one frame-synced
// instance, with scoreboards for launch address and buffer state at each flip.
module tb_er_scheduler;

   logic clk_sys = 1'b0;
   logic rst_sys;
   logic frame;

   er_scheduler_if #(.ADDRW(16)) if0 ();
   er_scheduler_if #(.ADDRW(16)) if1 ();

   logic buf_draw0, buf_disp0, done0, timeout0;
   logic buf_draw1, buf_disp1, done1, timeout1;

   er_scheduler #(
      .ADDRW(16), .TOW(24), .TIMEOUT(24'd100), .FRAME_SYNC(1'b0)
   ) u_dut0 (
      .clk_sys(clk_sys), .rst_sys(rst_sys), .frame(frame), .bus(if0.slave),
      .buf_draw(buf_draw0), .buf_disp(buf_disp0), .done(done0), .timeout(timeout0)
   );

   er_scheduler #(
      .ADDRW(16), .TOW(24), .TIMEOUT(24'd100), .FRAME_SYNC(1'b1)
   ) u_dut1 (
      .clk_sys(clk_sys), .rst_sys(rst_sys), .frame(frame), .bus(if1.slave),
      .buf_draw(buf_draw1), .buf_disp(buf_disp1), .done(done1), .timeout(timeout1)
   );

   always #5 clk_sys = ~clk_sys;

   int n_checks = 0;
   int n_errors = 0;
   int starts0  = 0;
   int starts1  = 0;
   logic [15:0] q_pc0 [$];
   logic [15:0] q_pc1 [$];
   logic [1:0]  q_buf0 [$];
   logic [1:0]  q_buf1 [$];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // scoreboard side: pop on each launch / flip
   always @(negedge clk_sys) begin
      if (!rst_sys) begin
         if (if0.er_start) begin
            starts0++;
            if (q_pc0.size() == 0) chk("sb_start0_unexpected", 1, 0);
            else                   chk("sb_er_pc0", if0.er_pc, q_pc0.pop_front());
         end
         if (done0) begin
            if (q_buf0.size() == 0) chk("sb_done0_unexpected", 1, 0);
            else                    chk("sb_buf0", {buf_draw0, buf_disp0}, q_buf0.pop_front());
         end
         if (if1.er_start) begin
            starts1++;
            if (q_pc1.size() == 0) chk("sb_start1_unexpected", 1, 0);
            else                   chk("sb_er_pc1", if1.er_pc, q_pc1.pop_front());
         end
         if (done1) begin
            if (q_buf1.size() == 0) chk("sb_done1_unexpected", 1, 0);
            else                    chk("sb_buf1", {buf_draw1, buf_disp1}, q_buf1.pop_front());
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_sys);
         #1;
      end
   endtask

   task automatic wait_ready0();
      int k = 0;
      while (!if0.req_ready && k < 20) begin
         step(1);
         k++;
      end
      chk("ready0_wait", if0.req_ready, 1);
   endtask

   task automatic send0(input logic [15:0] addr);
      wait_ready0();
      if0.req_valid = 1'b1;
      if0.req_addr  = addr;
      q_pc0.push_back(addr);
      step(1);
      if0.req_valid = 1'b0;
   endtask

   task automatic finish0(input logic [1:0] exp_buf);
      if0.er_done = 1'b1;
      step(1);
      if0.er_done = 1'b0;
      q_buf0.push_back(exp_buf);
      frame = 1'b1;
      step(1);
      frame = 1'b0;
      chk("done0_pulse", done0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      rst_sys = 1'b1;
      frame   = 1'b0;
      if0.req_valid = 1'b0; if0.req_addr = '0; if0.er_busy = 1'b0; if0.er_done = 1'b0;
      if1.req_valid = 1'b0; if1.req_addr = '0; if1.er_busy = 1'b0; if1.er_done = 1'b0;
      step(2);

      chk("rst_ready",   if0.req_ready, 0);
      chk("rst_start",   if0.er_start, 0);
      chk("rst_pc",      if0.er_pc, 0);
      chk("rst_buf",     {buf_draw0, buf_disp0}, 2'b10);
      chk("rst_done",    done0, 0);
      chk("rst_timeout", timeout0, 0);
      rst_sys = 1'b0;
      step(1);
      chk("ready_after_reset", if0.req_ready, 1);

      // immediate launch, single start pulse, flip on frame
      send0(16'h0040);
      chk("t1_start",    if0.er_start, 1);
      chk("t1_pc",       if0.er_pc, 16'h0040);
      chk("t1_ready_lo", if0.req_ready, 0);
      step(1);
      chk("t1_start_once", if0.er_start, 0);
      step(10);
      if0.er_done = 1'b1;
      step(1);
      if0.er_done = 1'b0;
      step(5);
      chk("t1_no_flip_before_frame", {done0, buf_draw0, buf_disp0}, 3'b010);
      q_buf0.push_back(2'b01);
      frame = 1'b1;
      step(1);
      frame = 1'b0;
      chk("t1_done",     done0, 1);
      chk("t1_buf",      {buf_draw0, buf_disp0}, 2'b01);
      chk("t1_ready_hi", if0.req_ready, 1);
      step(1);
      chk("t1_done_once", done0, 0);

      // watchdog: expiry exactly 100 cycles after er_start
      send0(16'h0100);
      step(99);
      chk("t3_no_early_timeout", timeout0, 0);
      step(1);
      chk("t3_timeout",  timeout0, 1);
      chk("t3_ready",    if0.req_ready, 1);
      chk("t3_buf_kept", {buf_draw0, buf_disp0}, 2'b01);
      send0(16'h0200);
      chk("t3_timeout_cleared", timeout0, 0);
      chk("t3b_start", if0.er_start, 1);
      finish0(2'b10);

      // engine busy holds off the launch
      if0.er_busy = 1'b1;
      send0(16'h0300);
      chk("t4_hold_start", if0.er_start, 0);
      for (int i = 0; i < 49; i++) begin
         step(1);
         chk("t4_hold_start", if0.er_start, 0);
      end
      if0.er_busy = 1'b0;
      step(1);
      chk("t4_start", if0.er_start, 1);
      step(1);
      chk("t4_start_once", if0.er_start, 0);
      finish0(2'b01);

      // er_done coincides with expiry: completion wins
      send0(16'h0400);
      step(99);
      if0.er_done = 1'b1;
      step(1);
      if0.er_done = 1'b0;
      chk("t5_no_timeout", timeout0, 0);
      chk("t5_in_flip",    {if0.req_ready, done0}, 2'b00);
      q_buf0.push_back(2'b10);
      frame = 1'b1;
      step(1);
      frame = 1'b0;
      chk("t5_done", done0, 1);
      send0(16'h0500);
      finish0(2'b01);

      // frame-synced instance; frame in the handshake cycle is ignored
      chk("t2_ready", if1.req_ready, 1);
      if1.req_valid = 1'b1;
      if1.req_addr  = 16'h00A0;
      q_pc1.push_back(16'h00A0);
      frame = 1'b1;
      step(1);
      if1.req_valid = 1'b0;
      frame = 1'b0;
      chk("t2_ready_lo", if1.req_ready, 0);
      for (int i = 0; i < 14; i++) begin
         chk("t2_no_early_start", if1.er_start, 0);
         step(1);
      end
      frame = 1'b1;
      step(1);
      frame = 1'b0;
      chk("t2_start", if1.er_start, 1);
      step(1);
      chk("t2_start_once", if1.er_start, 0);
      if1.er_done = 1'b1;
      step(1);
      if1.er_done = 1'b0;
      q_buf1.push_back(2'b01);
      frame = 1'b1;
      step(1);
      frame = 1'b0;
      chk("t2_done", done1, 1);

      // asynchronous reset mid-BUSY
      send0(16'h0600);
      step(5);
      rst_sys = 1'b1;
      #1;
      chk("t6_ready",   if0.req_ready, 0);
      chk("t6_start",   if0.er_start, 0);
      chk("t6_pc",      if0.er_pc, 0);
      chk("t6_buf",     {buf_draw0, buf_disp0}, 2'b10);
      chk("t6_flags",   {done0, timeout0}, 2'b00);
      chk("t6_buf1",    {buf_draw1, buf_disp1}, 2'b10);
      rst_sys = 1'b0;
      step(1);
      chk("t6_ready_after_release", if0.req_ready, 1);

      step(3);
      chk("sb_queues_empty", q_pc0.size() + q_pc1.size() + q_buf0.size() + q_buf1.size(), 0);
      chk("starts0_count", starts0, 7);
      chk("starts1_count", starts1, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
